// File: rtl/fpu_stream_pkg.sv
// Shared types and constants for the divider stream master.
package fpu_stream_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2,
    WAIT_Z = 2'd3
  } state_e;

  // One queued operation: dividend in the upper half, divisor in the lower half.
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/fpu_div_stream_master_if.sv
// Command, divider and result handshake bundle of the divider stream master.
interface fpu_div_stream_master_if;
  import fpu_stream_pkg::*;

  logic [FP_W-1:0] cmd_a;
  logic [FP_W-1:0] cmd_b;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [FP_W-1:0] div_a;
  logic            div_a_stb;
  logic            div_a_ack;
  logic [FP_W-1:0] div_b;
  logic            div_b_stb;
  logic            div_b_ack;
  logic [FP_W-1:0] div_z;
  logic            div_z_stb;
  logic            div_z_ack;
  logic [FP_W-1:0] res_z;
  logic            res_valid;
  logic            res_ready;

  // View of the stream master itself.
  modport master (
    input  cmd_a, cmd_b, cmd_valid, div_a_ack, div_b_ack, div_z, div_z_stb, res_ready,
    output cmd_ready, div_a, div_a_stb, div_b, div_b_stb, div_z_ack, res_z, res_valid
  );

  // View of the surrounding host fabric and divider core.
  modport slave (
    output cmd_a, cmd_b, cmd_valid, div_a_ack, div_b_ack, div_z, div_z_stb, res_ready,
    input  cmd_ready, div_a, div_a_stb, div_b, div_b_stb, div_z_ack, res_z, res_valid
  );
endinterface

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO holding operand pairs until the FSM picks them up.
module fpu_cmd_fifo
  import fpu_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok) begin
      wr_d = wr_q + AW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok) begin
      rd_d = rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= {AW{1'b0}};
      rd_q    <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only read when occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/fpu_div_stream_master.sv
// Feeds a stb/ack divider core from a command FIFO, one operation at a time,
// and returns quotients in order through a single-entry result register.
module fpu_div_stream_master
  import fpu_stream_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  fpu_div_stream_master_if.master        bus,
  output logic                           busy,
  output logic                           err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [FP_W-1:0] div_a_q, div_a_d;
  logic [FP_W-1:0] div_b_q, div_b_d;
  logic            a_stb_q, a_stb_d;
  logic            b_stb_q, b_stb_d;
  logic [FP_W-1:0] res_z_q, res_z_d;
  logic            res_valid_q, res_valid_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            live_q;

  logic            fifo_full, fifo_empty, fifo_pop;
  cmd_t            head;
  logic            res_free, z_ack;

  // Result slot can take a new value if empty now or being drained this cycle.
  assign res_free = !res_valid_q || bus.res_ready;
  assign z_ack    = (state_q == WAIT_Z) && res_free;

  // cmd_ready stays low while reset is held and rises on the first edge after release.
  assign bus.cmd_ready = live_q && !fifo_full;

  fpu_cmd_fifo #(.DEPTH(DEPTH), .W(2 * FP_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid && bus.cmd_ready),
    .din   ({bus.cmd_a, bus.cmd_b}),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Operation sequencing, timeout watchdog and result slot next-state.
  always_comb begin
    state_d     = state_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    a_stb_d     = a_stb_q;
    b_stb_d     = b_stb_q;
    res_z_d     = res_z_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    fifo_pop    = 1'b0;
    if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          div_a_d  = head.a;
          div_b_d  = head.b;
          a_stb_d  = 1'b1;
          state_d  = SEND_A;
        end else begin
          state_d  = IDLE;
        end
      end
      SEND_A: begin
        if (a_stb_q && bus.div_a_ack) begin
          a_stb_d = 1'b0;
          b_stb_d = 1'b1;
          state_d = SEND_B;
        end else begin
          state_d = SEND_A;
        end
      end
      SEND_B: begin
        if (b_stb_q && bus.div_b_ack) begin
          b_stb_d = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          state_d = WAIT_Z;
        end else begin
          state_d = SEND_B;
        end
      end
      WAIT_Z: begin
        if (bus.div_z_stb && z_ack) begin
          res_z_d     = bus.div_z;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          // Counter parks at the limit until the result slot can take the NaN.
          if (res_free) begin
            err_d       = 1'b1;
            res_z_d     = QNAN;
            res_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d     = WAIT_Z;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = WAIT_Z;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All control and datapath registers; everything is discarded on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      div_a_q     <= {FP_W{1'b0}};
      div_b_q     <= {FP_W{1'b0}};
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      res_z_q     <= {FP_W{1'b0}};
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      a_stb_q     <= a_stb_d;
      b_stb_q     <= b_stb_d;
      res_z_q     <= res_z_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      live_q      <= 1'b1;
    end
  end

  assign bus.div_a     = div_a_q;
  assign bus.div_a_stb = a_stb_q;
  assign bus.div_b     = div_b_q;
  assign bus.div_b_stb = b_stb_q;
  assign bus.div_z_ack = z_ack;
  assign bus.res_z     = res_z_q;
  assign bus.res_valid = res_valid_q;
  assign busy          = (state_q != IDLE) || !fifo_empty;
  assign err_timeout   = err_q;

endmodule
